// File: rtl/state_stats_collector.sv
// state_stats_collector: counts, per node, how many ticks of a programmed
// window each node spends infected, then streams the per-node totals out
// over a valid/ready interface and pulses done after the last one.
module state_stats_collector #(
  parameter int NUM_NODES = 10,
  parameter int CNT_W     = 32,
  parameter int TICK_W    = 32,
  parameter int IDX_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [TICK_W-1:0]    num_ticks,
  input  logic [NUM_NODES-1:0] states,
  output logic                 busy,
  output logic                 done,
  output logic                 cnt_valid,
  input  logic                 cnt_ready,
  output logic [IDX_W-1:0]     cnt_node,
  output logic [CNT_W-1:0]     cnt_data,
  output logic                 cnt_last
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q [NUM_NODES];
  logic [CNT_W-1:0]   cnt_d [NUM_NODES];
  logic [TICK_W-1:0]  tick_q;
  logic [TICK_W-1:0]  ticks_q;
  logic [IDX_W-1:0]   idx_q;
  logic               busy_q;
  logic               done_q;
  logic               valid_q;
  logic               last_q;
  logic [CNT_W-1:0]   data_d;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic             en);
    if (en && !(&v)) return v + CNT_W'(1);
    return v;
  endfunction

  // Next occupancy value for every node given this cycle's state vector.
  always_comb begin
    for (int i = 0; i < NUM_NODES; i++) begin
      cnt_d[i] = sat_inc(cnt_q[i], states[i]);
    end
  end

  // Select the counter addressed by the drain index.
  always_comb begin
    data_d = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      if (idx_q == IDX_W'(i)) data_d = cnt_q[i];
    end
  end

  // Control FSM: window sampling, result drain and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      ticks_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      for (int i = 0; i < NUM_NODES; i++) cnt_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // The states vector on the accepting cycle is deliberately not sampled.
          if (start) begin
            ticks_q <= num_ticks;
            tick_q  <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            for (int i = 0; i < NUM_NODES; i++) cnt_q[i] <= '0;
            if (num_ticks == '0) begin
              state_q <= DRAIN;
              valid_q <= 1'b1;
              last_q  <= (LAST_IDX == '0);
            end else begin
              state_q <= SAMPLE;
            end
          end
        end
        SAMPLE: begin
          for (int i = 0; i < NUM_NODES; i++) cnt_q[i] <= cnt_d[i];
          tick_q <= tick_q + TICK_W'(1);
          if (tick_q == ticks_q - TICK_W'(1)) begin
            state_q <= DRAIN;
            valid_q <= 1'b1;
            last_q  <= (LAST_IDX == '0);
          end
        end
        DRAIN: begin
          if (cnt_ready) begin
            if (last_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              idx_q   <= '0;
            end else begin
              idx_q  <= idx_q + IDX_W'(1);
              last_q <= ((idx_q + IDX_W'(1)) == LAST_IDX);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign cnt_valid = valid_q;
  assign cnt_last  = last_q;
  assign cnt_node  = idx_q;
  // Counters stay visible internally in IDLE, but the stream reads zero.
  assign cnt_data  = valid_q ? data_d : '0;

endmodule

// File: tb/tb_state_stats_collector.sv
// Bench for state_stats_collector: a 32-bit-counter instance and a 4-bit
// (saturating) instance share all inputs; a window-level model predicts
// the totals and a per-cycle process checks both streams against it.
module tb_state_stats_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] num_ticks;
  logic [9:0]  states;
  logic        cnt_ready;

  logic        busy_a, done_a, cnt_valid_a, cnt_last_a;
  logic [3:0]  cnt_node_a;
  logic [31:0] cnt_data_a;
  logic        busy_b, done_b, cnt_valid_b, cnt_last_b;
  logic [3:0]  cnt_node_b;
  logic [3:0]  cnt_data_b;

  state_stats_collector #(.NUM_NODES(10), .CNT_W(32), .TICK_W(32), .IDX_W(4)) dut_a (
    .clk(clk), .rst(rst), .start(start), .num_ticks(num_ticks), .states(states),
    .busy(busy_a), .done(done_a), .cnt_valid(cnt_valid_a), .cnt_ready(cnt_ready),
    .cnt_node(cnt_node_a), .cnt_data(cnt_data_a), .cnt_last(cnt_last_a)
  );

  state_stats_collector #(.NUM_NODES(10), .CNT_W(4), .TICK_W(32), .IDX_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start), .num_ticks(num_ticks), .states(states),
    .busy(busy_b), .done(done_b), .cnt_valid(cnt_valid_b), .cnt_ready(cnt_ready),
    .cnt_node(cnt_node_b), .cnt_data(cnt_data_b), .cnt_last(cnt_last_b)
  );

  always #5 clk = ~clk;

  int     vectors    = 0;
  int     miscompares = 0;
  longint exp_a [10];
  longint exp_b [10];
  longint got_a [10];
  longint got_b [10];
  int     exp_idx  = 0;
  bit     pend     = 1'b0;
  int     hs_cnt   = 0;
  int     busy_cyc = 0;
  logic [9:0] pat [4];
  int     plen = 1;

  task automatic check(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (rst) begin
      exp_idx = 0;
      pend    = 1'b0;
    end else begin
      check("done_a", done_a, pend);
      check("done_b", done_b, pend);
      if (busy_a) busy_cyc++;
      if (!busy_a) check("idle_valid_a", cnt_valid_a, 0);
      if (!busy_b) check("idle_valid_b", cnt_valid_b, 0);
      if (cnt_valid_a) begin
        check("node_a", cnt_node_a, exp_idx);
        check("data_a", cnt_data_a, exp_a[exp_idx]);
        check("last_a", cnt_last_a, exp_idx == 9);
      end
      if (cnt_valid_b) begin
        check("node_b", cnt_node_b, exp_idx);
        check("data_b", cnt_data_b, exp_b[exp_idx]);
        check("last_b", cnt_last_b, exp_idx == 9);
      end
      pend = cnt_valid_a && cnt_ready && cnt_last_a;
      if (cnt_valid_a && cnt_ready) begin
        got_a[exp_idx] = cnt_data_a;
        got_b[exp_idx] = cnt_data_b;
        hs_cnt++;
        exp_idx = (exp_idx == 9) ? 0 : exp_idx + 1;
      end
    end
  end

  // One full window: start, ticks samples from pat[], drain until done.
  // bp selects a 1/0/0/1 ready pattern; poke_at pulses start mid-window.
  task automatic run_window(input int ticks, input int bp, input int poke_at);
    longint s;
    int cyc;
    logic [3:0] rpat;
    rpat = 4'b1001;
    for (int i = 0; i < 10; i++) begin
      s = 0;
      for (int k = 0; k < ticks; k++) s += pat[k % plen][i];
      exp_a[i] = s;
      exp_b[i] = (s > 15) ? 15 : s;
      got_a[i] = -1;
      got_b[i] = -1;
    end
    @(posedge clk); #1;
    start = 1'b1; num_ticks = ticks; cnt_ready = 1'b1;
    hs_cnt = 0; busy_cyc = 0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < ticks; k++) begin
      states = pat[k % plen];
      if (k == poke_at) begin start = 1'b1; num_ticks = 2; end
      else start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    states = 10'h000;
    check("drain_latency", cnt_valid_a, 1);
    cyc = 0;
    while (!done_a && cyc < 100) begin
      cnt_ready = bp ? rpat[3 - (cyc % 4)] : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    cnt_ready = 1'b1;
    check("done_seen", done_a, 1);
    check("handshakes", hs_cnt, 10);
    if (!bp) check("busy_cycles", busy_cyc, ticks + 10);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen_done;
    rst = 1'b1; start = 1'b0; num_ticks = 0; states = 10'h000; cnt_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin exp_a[i] = 0; exp_b[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_valid", cnt_valid_a, 0);
    check("rst_last", cnt_last_a, 0);
    check("rst_node", cnt_node_a, 0);
    check("rst_data", cnt_data_a, 0);
    rst = 1'b0;

    // Single infected node over 5 ticks.
    pat[0] = 10'b0000000001; plen = 1;
    run_window(5, 0, -1);
    check("t1_node0", got_a[0], 5);
    check("t1_node9", got_a[9], 0);

    // Alternating all/none, 8 ticks -> 4 each.
    pat[0] = 10'h3FF; pat[1] = 10'h000; plen = 2;
    run_window(8, 0, -1);
    check("t2_node0", got_a[0], 4);
    check("t2_node5", got_a[5], 4);
    check("t2_node9", got_b[9], 4);

    // Backpressure.
    pat[0] = 10'h200; plen = 1;
    run_window(3, 1, -1);
    check("t3_node9", got_a[9], 3);
    check("t3_node0", got_a[0], 0);

    // Saturation on the 4-bit instance.
    pat[0] = 10'h001; plen = 1;
    run_window(20, 0, -1);
    check("t4_wide_node0", got_a[0], 20);
    check("t4_sat_node0", got_b[0], 15);
    check("t4_sat_node1", got_b[1], 0);

    // Zero-length window.
    pat[0] = 10'h3FF; plen = 1;
    run_window(0, 0, -1);
    check("t5_node0", got_a[0], 0);
    check("t5_node9", got_a[9], 0);

    // Reset at tick 2 of a 10-tick window.
    @(posedge clk); #1;
    start = 1'b1; num_ticks = 10;
    @(posedge clk); #1;
    start = 1'b0; states = 10'h3FF;
    repeat (2) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy_a, 0);
    check("abort_valid", cnt_valid_a, 0);
    check("abort_done", done_a, 0);
    check("abort_node", cnt_node_a, 0);
    check("abort_data", cnt_data_a, 0);
    check("abort_last", cnt_last_a, 0);
    @(posedge clk); #1;
    rst = 1'b0; states = 10'h000;
    seen_done = 0;
    repeat (15) begin @(posedge clk); #1; if (done_a) seen_done++; end
    check("abort_no_done", seen_done, 0);

    // Fresh window after the abort.
    pat[0] = 10'h001; plen = 1;
    run_window(2, 0, -1);
    check("t6_node0", got_a[0], 2);

    // Start pulsed mid-window (with a different length) must be ignored.
    run_window(6, 0, 3);
    check("t7_node0", got_a[0], 6);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
